// File: rtl/clock_pkg.sv
// Shared clock-display definitions: edit-field encodings, BCD limits and the
// bit layout of the packed display word (also used by the splitter).
package clock_pkg;

   typedef enum logic [1:0] {
      FIELD_IDLE = 2'b00,
      FIELD_HOUR = 2'b01,
      FIELD_MIN  = 2'b10,
      FIELD_SEC  = 2'b11
   } field_t;

   localparam logic [7:0] BLANK_CODE_DEFAULT = 8'hFF;

   localparam logic [7:0] HOUR_MAX   = 8'h23;
   localparam logic [7:0] MINSEC_MAX = 8'h59;
   localparam logic [7:0] HOUR_NOON  = 8'h12;

   localparam int unsigned DT_PM         = 31;
   localparam int unsigned DT_TIME_MODE  = 30;
   localparam int unsigned DT_SEL_HI     = 29;
   localparam int unsigned DT_SEL_LO     = 28;
   localparam int unsigned DT_BLANK_HOUR = 27;
   localparam int unsigned DT_BLANK_MIN  = 26;
   localparam int unsigned DT_BLANK_SEC  = 25;
   localparam int unsigned DT_ERR        = 24;
   localparam int unsigned DT_HOUR_LSB   = 16;
   localparam int unsigned DT_MIN_LSB    = 8;
   localparam int unsigned DT_SEC_LSB    = 0;

   // True when both nibbles of a packed-BCD byte are decimal digits.
   function automatic logic bcd_digits_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/hour12_conv.sv
// Combinational 24-hour to 12-hour conversion of a valid packed-BCD hour.
module hour12_conv
   import clock_pkg::*;
(
   input  logic [7:0] hour,
   output logic [7:0] hour12,
   output logic       pm
);

   always_comb begin
      hour12 = hour;
      pm     = 1'b0;
      if (hour == 8'h00) begin
         hour12 = HOUR_NOON;
      end else if (hour == HOUR_NOON) begin
         pm = 1'b1;
      end else if (hour > HOUR_NOON) begin
         pm = 1'b1;
         // Subtract 12 directly in BCD: 13-19 -> 01-07, 20-21 -> 08-09, 22-23 -> 10-11.
         if (hour[7:4] == 4'h1) begin
            hour12 = {4'h0, hour[3:0] - 4'd2};
         end else if (hour[3:0] >= 4'd2) begin
            hour12 = {4'h1, hour[3:0] - 4'd2};
         end else begin
            hour12 = {4'h0, hour[3:0] + 4'd8};
         end
      end
   end

endmodule

// File: rtl/time_merger.sv
// Merges the running BCD time, 12/24-hour conversion, validity and the
// set-mode field selection with blink blanking into one registered word.
module time_merger
   import clock_pkg::*;
#(
   parameter logic [7:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
   input  logic        CP,
   input  logic        _CR,
   input  logic [7:0]  cur_sec,
   input  logic [7:0]  cur_min,
   input  logic [7:0]  cur_hour,
   input  logic        time_mode,
   input  logic        mode,
   input  logic        adj_key,
   input  logic        blink_tick,
   output logic [31:0] display_time,
   output logic [1:0]  field_sel
);

   field_t      field_q, field_d;
   logic        phase_q, phase_d;
   logic [7:0]  conv_hour;
   logic        conv_pm;
   logic        err;
   logic [7:0]  hour_v;
   logic        pm_v;
   logic        blank_hour, blank_min, blank_sec;
   logic [31:0] disp_d;

   hour12_conv u_hour12_conv (
      .hour   (cur_hour),
      .hour12 (conv_hour),
      .pm     (conv_pm)
   );

   always_comb begin
      field_d = field_q;
      if (!mode) begin
         field_d = FIELD_IDLE;
      end else if (adj_key) begin
         case (field_q)
            FIELD_IDLE: field_d = FIELD_HOUR;
            FIELD_HOUR: field_d = FIELD_MIN;
            FIELD_MIN:  field_d = FIELD_SEC;
            default:    field_d = FIELD_IDLE;
         endcase
      end

      // A field change restarts the phase so the new field is visible at once.
      if (field_d != field_q) begin
         phase_d = 1'b0;
      end else if (blink_tick) begin
         phase_d = ~phase_q;
      end else begin
         phase_d = phase_q;
      end
   end

   always_comb begin
      err = !bcd_digits_ok(cur_hour) || !bcd_digits_ok(cur_min) ||
            !bcd_digits_ok(cur_sec) || (cur_hour > HOUR_MAX) ||
            (cur_min > MINSEC_MAX) || (cur_sec > MINSEC_MAX);

      hour_v = cur_hour;
      pm_v   = 1'b0;
      if (time_mode && !err) begin
         hour_v = conv_hour;
         pm_v   = conv_pm;
      end

      // Blanking follows the state being registered alongside the word.
      blank_hour = phase_d && (field_d == FIELD_HOUR);
      blank_min  = phase_d && (field_d == FIELD_MIN);
      blank_sec  = phase_d && (field_d == FIELD_SEC);

      disp_d                              = '0;
      disp_d[DT_PM]                       = pm_v;
      disp_d[DT_TIME_MODE]                = time_mode;
      disp_d[DT_SEL_HI:DT_SEL_LO]         = field_d;
      disp_d[DT_BLANK_HOUR]               = blank_hour;
      disp_d[DT_BLANK_MIN]                = blank_min;
      disp_d[DT_BLANK_SEC]                = blank_sec;
      disp_d[DT_ERR]                      = err;
      disp_d[DT_HOUR_LSB+7:DT_HOUR_LSB]   = blank_hour ? BLANK_CODE : hour_v;
      disp_d[DT_MIN_LSB+7:DT_MIN_LSB]     = blank_min  ? BLANK_CODE : cur_min;
      disp_d[DT_SEC_LSB+7:DT_SEC_LSB]     = blank_sec  ? BLANK_CODE : cur_sec;
   end

   always_ff @(posedge CP) begin
      if (!_CR) begin
         field_q      <= FIELD_IDLE;
         phase_q      <= 1'b0;
         display_time <= '0;
      end else begin
         field_q      <= field_d;
         phase_q      <= phase_d;
         display_time <= disp_d;
      end
   end

   assign field_sel = field_q;

endmodule

// File: tb/tb_time_merger.sv
// Directed bench for time_merger: vector table plus hand-written edit sequences.
module tb_time_merger;

   logic        CP;
   logic        cr_n;
   logic [7:0]  cur_sec, cur_min, cur_hour;
   logic        time_mode, mode, adj_key, blink_tick;
   logic [31:0] display_time;
   logic [1:0]  field_sel;

   int checks;
   int errors;

   typedef struct {
      string       name;
      logic        cr;
      logic [7:0]  hour;
      logic [7:0]  min;
      logic [7:0]  sec;
      logic        tm;
      logic        md;
      logic        adj;
      logic        blink;
      logic [31:0] exp_dt;
      logic [1:0]  exp_sel;
   } vec_t;

   vec_t vecs[$];

   time_merger #(.BLANK_CODE(8'hFF)) dut (
      .CP           (CP),
      ._CR          (cr_n),
      .cur_sec      (cur_sec),
      .cur_min      (cur_min),
      .cur_hour     (cur_hour),
      .time_mode    (time_mode),
      .mode         (mode),
      .adj_key      (adj_key),
      .blink_tick   (blink_tick),
      .display_time (display_time),
      .field_sel    (field_sel)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic add(input string name, input logic cr, input logic [7:0] hour,
                      input logic [7:0] min, input logic [7:0] sec, input logic tm,
                      input logic md, input logic adj, input logic blink,
                      input logic [31:0] exp_dt, input logic [1:0] exp_sel);
      vec_t v;
      v.name = name; v.cr = cr; v.hour = hour; v.min = min; v.sec = sec;
      v.tm = tm; v.md = md; v.adj = adj; v.blink = blink;
      v.exp_dt = exp_dt; v.exp_sel = exp_sel;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic cr, input logic [7:0] hour, input logic [7:0] min,
                        input logic [7:0] sec, input logic tm, input logic md,
                        input logic adj, input logic blink);
      @(negedge CP);
      cr_n = cr; cur_hour = hour; cur_min = min; cur_sec = sec;
      time_mode = tm; mode = md; adj_key = adj; blink_tick = blink;
      @(posedge CP);
      #1;
   endtask

   task automatic check_dt(input string name, input logic [31:0] exp_dt);
      checks++;
      if (display_time !== exp_dt) begin
         errors++;
         $display("FAIL %s: display_time=%h expected %h", name, display_time, exp_dt);
      end
   endtask

   task automatic check_sel(input string name, input logic [1:0] exp_sel);
      checks++;
      if (field_sel !== exp_sel) begin
         errors++;
         $display("FAIL %s: field_sel=%b expected %b", name, field_sel, exp_sel);
      end
   endtask

   initial begin
      logic [7:0] bcd_h, exp_h;
      int unsigned e;
      checks = 0;
      errors = 0;
      cr_n = 1'b0; cur_sec = '0; cur_min = '0; cur_hour = '0;
      time_mode = 1'b0; mode = 1'b0; adj_key = 1'b0; blink_tick = 1'b0;

      //   name          cr hour   min    sec    tm md adj bl  expected dt     sel
      add("rst0",        0, 8'h13, 8'h30, 8'h45, 1, 1, 1, 1, 32'h0000_0000, 2'd0);
      add("rst1",        0, 8'h13, 8'h30, 8'h45, 1, 1, 1, 1, 32'h0000_0000, 2'd0);
      add("h24_13",      1, 8'h13, 8'h30, 8'h45, 0, 0, 0, 0, 32'h0013_3045, 2'd0);
      add("h12_00",      1, 8'h00, 8'h30, 8'h45, 1, 0, 0, 0, 32'h4012_3045, 2'd0);
      add("h12_11",      1, 8'h11, 8'h30, 8'h45, 1, 0, 0, 0, 32'h4011_3045, 2'd0);
      add("h12_12",      1, 8'h12, 8'h30, 8'h45, 1, 0, 0, 0, 32'hC012_3045, 2'd0);
      add("h12_13",      1, 8'h13, 8'h30, 8'h45, 1, 0, 0, 0, 32'hC001_3045, 2'd0);
      add("h12_23",      1, 8'h23, 8'h30, 8'h45, 1, 0, 0, 0, 32'hC011_3045, 2'd0);
      add("h12_20",      1, 8'h20, 8'h30, 8'h45, 1, 0, 0, 0, 32'hC008_3045, 2'd0);
      add("err_min5A",   1, 8'h15, 8'h5A, 8'h45, 1, 0, 0, 0, 32'h4115_5A45, 2'd0);
      add("err_hour24",  1, 8'h24, 8'h30, 8'h45, 1, 0, 0, 0, 32'h4124_3045, 2'd0);
      add("err_sec60",   1, 8'h10, 8'h30, 8'h60, 0, 0, 0, 0, 32'h0110_3060, 2'd0);
      add("idle_blink",  1, 8'h10, 8'h30, 8'h45, 0, 0, 0, 1, 32'h0010_3045, 2'd0);
      add("to_hour",     1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0, 32'h1010_3045, 2'd1);
      add("blank_hour",  1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 1, 32'h18FF_3045, 2'd1);
      add("blank_h_pm",  1, 8'h14, 8'h30, 8'h45, 1, 1, 0, 0, 32'hD8FF_3045, 2'd1);
      add("adj_blink",   1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 1, 32'h2010_3045, 2'd2);
      add("blank_min",   1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 1, 32'h2410_FF45, 2'd2);
      add("unblank_min", 1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 1, 32'h2010_3045, 2'd2);
      add("to_sec",      1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0, 32'h3010_3045, 2'd3);
      add("blank_sec",   1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 1, 32'h3210_30FF, 2'd3);
      add("to_idle",     1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0, 32'h0010_3045, 2'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].cr, vecs[i].hour, vecs[i].min, vecs[i].sec,
               vecs[i].tm, vecs[i].md, vecs[i].adj, vecs[i].blink);
         check_dt(vecs[i].name, vecs[i].exp_dt);
         check_sel(vecs[i].name, vecs[i].exp_sel);
      end

      // Four adj_key pulses separated by quiet cycles walk the whole field ring.
      for (int unsigned p = 0; p < 4; p++) begin
         drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0);
         check_sel("adj_ring", 2'((p + 1) % 4));
         drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 0);
         check_sel("adj_ring_hold", 2'((p + 1) % 4));
      end

      // Mode falls mid-edit while adj_key is high: back to IDLE, nothing blanked.
      drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0);
      drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0);
      check_sel("pre_drop", 2'd2);
      drive(1, 8'h10, 8'h30, 8'h45, 0, 0, 1, 0);
      check_sel("mode_drop", 2'd0);
      check_dt("mode_drop", 32'h0010_3045);

      // Reset while the hour field is blanked, overriding adj_key and blink_tick.
      drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 1, 0);
      drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 1);
      check_dt("pre_rst_blank", 32'h18FF_3045);
      drive(0, 8'h10, 8'h30, 8'h45, 0, 1, 1, 1);
      check_dt("mid_rst", 32'h0000_0000);
      check_sel("mid_rst", 2'd0);
      drive(1, 8'h10, 8'h30, 8'h45, 0, 1, 0, 0);
      check_dt("post_rst", 32'h0010_3045);
      check_sel("post_rst", 2'd0);

      // Every valid hour in 12-hour form against an arithmetic model.
      for (int unsigned h = 0; h < 24; h++) begin
         bcd_h = 8'(((h / 10) << 4) | (h % 10));
         e = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
         exp_h = 8'(((e / 10) << 4) | (e % 10));
         drive(1, bcd_h, 8'h00, 8'h59, 1, 0, 0, 0);
         check_dt("h12_sweep", {(h >= 12) ? 1'b1 : 1'b0, 7'b100_0000, exp_h, 8'h00, 8'h59});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_merger.md
TIME_MERGER -- requirements
Module: time_merger

Interface
REQ-001 The block SHALL have parameter BLANK_CODE, default 8'hFF, the byte driven into a blanked BCD field.
REQ-002 The block SHALL have port CP, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port _CR, input, 1, the synchronous active-low clear, sampled on the CP rising edge.
REQ-004 The block SHALL have port cur_sec, input, 8, packed-BCD seconds 00-59.
REQ-005 The block SHALL have port cur_min, input, 8, packed-BCD minutes 00-59.
REQ-006 The block SHALL have port cur_hour, input, 8, packed-BCD hours 00-23, 24-hour form.
REQ-007 The block SHALL have port time_mode, input, 1, 0=24-hour display, 1=12-hour display.
REQ-008 The block SHALL have port mode, input, 1, 0=run view, 1=set view.
REQ-009 The block SHALL have port adj_key, input, 1, one-cycle pulse that advances the edit field.
REQ-010 The block SHALL have port blink_tick, input, 1, one-cycle pulse that toggles the blink phase.
REQ-011 The block SHALL have port display_time, output, 32, registered packed display word.
REQ-012 The block SHALL have port field_sel, output, 2, registered current edit field.

Function
REQ-013 display_time SHALL be packed as [31]=PM, [30]=time_mode, [29:28]=field_sel, [27]=blank_hour, [26]=blank_min, [25]=blank_sec, [24]=err, [23:16]=hour, [15:8]=min, [7:0]=sec.
REQ-014 display_time SHALL reflect the inputs sampled on the edge of the same cycle, giving a latency of 1 CP cycle.
REQ-015 With time_mode=0, hour SHALL equal cur_hour and PM SHALL be 0.
REQ-016 With time_mode=1, the hour SHALL map as 00->12 with PM=0, 01-11 passed through with PM=0, 12->12 with PM=1, and 13-23 converted to hour-12 in BCD with PM=1 (e.g. 20->08, 23->11).
REQ-017 err SHALL be 1 when any input nibble exceeds 9, cur_hour>23, or cur_min/cur_sec>59; on err all three fields SHALL pass through unconverted and PM SHALL be 0.
REQ-018 The field FSM SHALL have states IDLE=00, HOUR=01, MIN=10 and SEC=11.
REQ-019 While mode=1, adj_key SHALL advance the FSM IDLE->HOUR->MIN->SEC->IDLE.
REQ-020 While mode=0, the FSM SHALL enter IDLE on the next edge and SHALL ignore adj_key.
REQ-021 When mode falls while adj_key is high, the FSM SHALL go to IDLE.
REQ-022 The blink phase register SHALL toggle on blink_tick.
REQ-023 The blink phase register SHALL clear to 0 on any FSM state change, so a newly selected field is shown immediately.
REQ-024 When adj_key and blink_tick coincide, the FSM SHALL advance and the phase SHALL be 0.
REQ-025 A field SHALL be blanked when the phase is 1 and field_sel selects that field; its byte SHALL be BLANK_CODE and its blank flag SHALL be 1.
REQ-026 In IDLE, no field SHALL be blanked, irrespective of the phase.
REQ-027 Blanking SHALL apply after 12-hour conversion; PM SHALL remain valid while the hour is blanked.

Reset
REQ-028 With _CR=0 at a CP edge, display_time SHALL be 32'h0000_0000, field_sel SHALL be 00, and the phase SHALL be 0.
REQ-029 Reset SHALL override adj_key and blink_tick in the same cycle.
REQ-030 Reset asserted mid-edit SHALL return the FSM to IDLE with no blanking on the first post-reset output.

Structure
REQ-031 Package clock_pkg SHALL hold the field encodings, the BLANK_CODE default, BCD limit constants (8'h23, 8'h59, 8'h12) and the display word bit positions, shared with splitter.
REQ-032 The combinational 24-to-12-hour BCD conversion SHALL be a sub-module named hour12_conv, with inputs hour and outputs hour12 and pm.

Verification
REQ-033 A bench SHALL drive _CR=0 for 2 cycles with arbitrary inputs and check display_time=0 and field_sel=00.
REQ-034 A bench SHALL drive time_mode=1 with hours 00, 11, 12, 13, 23 and check hour/PM of 12/0, 11/0, 12/1, 01/1, 11/1 one cycle later.
REQ-035 A bench SHALL drive mode=1 with 4 adj_key pulses and check field_sel 01, 10, 11, 00.
REQ-036 A bench SHALL set sel=MIN and pulse blink_tick and check [15:8]=FF with [26]=1; a second blink_tick SHALL restore the minutes.
REQ-037 A bench SHALL drive cur_min=8'h5A and check err=1 with fields passed through.
REQ-038 A bench SHALL drive adj_key and blink_tick together in HOUR and check sel=MIN and no blanking; dropping mode mid-edit SHALL give field_sel=00 next cycle.
